// File: rtl/mannix_ddr_dma_if.sv
`default_nettype none
// ============================================================================
//  Module      : mannix_ddr_dma_if
//  Description : Bundles the farm-side request/data channels and the DDR
//                controller command/data channels of the mannix DDR DMA.
//                master : view taken by the DMA engine
//                slave  : view taken by the surrounding farm + DDR controller
//  Ports       : rd_req_* / rd_data* / rd_done   farm read path
//                wr_req_* / wr_data* / wr_done   farm write path
//                ddr_cmd_* / ddr_wdata* / ddr_rdata*  DDR controller port
//  Revision    : 1.0  initial release
// ============================================================================
interface mannix_ddr_dma_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int BLEN_W = 5
);
    // farm read path
    logic              rd_req_valid;
    logic [31:0]       rd_req_addr;
    logic [LEN_W-1:0]  rd_req_len;
    logic              rd_req_ready;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_last;
    logic              rd_done;
    // farm write path
    logic              wr_req_valid;
    logic [31:0]       wr_req_addr;
    logic [LEN_W-1:0]  wr_req_len;
    logic              wr_req_ready;
    logic              wr_data_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_ready;
    logic              wr_done;
    // DDR controller port
    logic              ddr_cmd_valid;
    logic              ddr_cmd_ready;
    logic              ddr_cmd_we;
    logic [31:0]       ddr_cmd_addr;
    logic [BLEN_W-1:0] ddr_cmd_blen;
    logic              ddr_wdata_valid;
    logic [DATA_W-1:0] ddr_wdata;
    logic              ddr_wdata_ready;
    logic              ddr_rdata_valid;
    logic [DATA_W-1:0] ddr_rdata;

    modport master (
        input  rd_req_valid, rd_req_addr, rd_req_len,
        output rd_req_ready, rd_data_valid, rd_data, rd_data_last, rd_done,
        input  wr_req_valid, wr_req_addr, wr_req_len, wr_data_valid, wr_data,
        output wr_req_ready, wr_data_ready, wr_done,
        output ddr_cmd_valid, ddr_cmd_we, ddr_cmd_addr, ddr_cmd_blen,
        input  ddr_cmd_ready,
        output ddr_wdata_valid, ddr_wdata,
        input  ddr_wdata_ready, ddr_rdata_valid, ddr_rdata
    );

    modport slave (
        output rd_req_valid, rd_req_addr, rd_req_len,
        input  rd_req_ready, rd_data_valid, rd_data, rd_data_last, rd_done,
        output wr_req_valid, wr_req_addr, wr_req_len, wr_data_valid, wr_data,
        input  wr_req_ready, wr_data_ready, wr_done,
        input  ddr_cmd_valid, ddr_cmd_we, ddr_cmd_addr, ddr_cmd_blen,
        output ddr_cmd_ready,
        input  ddr_wdata_valid, ddr_wdata,
        output ddr_wdata_ready, ddr_rdata_valid, ddr_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mannix_ddr_dma.sv
`default_nettype none
// ============================================================================
//  Module      : mannix_ddr_dma
//  Description : Bridges the memory farm's read/write DDR request paths to the
//                external DDR controller. Each request is split into bursts of
//                at most BURST_MAX beats; read and write requests are granted
//                round-robin (read first after reset). One burst in flight.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset
//                bus  - mannix_ddr_dma_if.master (farm + DDR channels)
//  Options     : `define MANNIX_DDR_BOUNDARY_EN to keep every burst inside one
//                2^BOUND_LOG2-byte aligned region.
//  Revision    : 1.0  initial release
// ============================================================================
module mannix_ddr_dma #(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int BURST_MAX  = 16,
    parameter int BLEN_W     = 5,
    parameter int BOUND_LOG2 = 12
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mannix_ddr_dma_if.master bus
);
    localparam int c_WORD_BYTES = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_DATA = 3'd2,
        WR_CMD  = 3'd3,
        WR_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [BLEN_W-1:0] r_beat_cnt;
    logic              r_is_wr;
    logic              r_prefer_rd;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [DATA_W-1:0] r_rd_data;

    logic [BLEN_W-1:0] w_blen;
    logic              w_beat;
    logic              w_burst_end;
    logic              w_req_end;
    logic              w_rd_grant;
    logic              w_wr_grant;
    logic              w_rd_req_ready;
    logic              w_wr_req_ready;
    logic              w_cmd_valid;
    logic              w_wr_data_ready;
    logic              w_ddr_wdata_valid;
    logic              w_rd_done;
    logic              w_wr_done;

`ifdef MANNIX_DDR_BOUNDARY_EN
    localparam logic [31:0] c_BOUND_MASK = (32'd1 << BOUND_LOG2) - 32'd1;
    // Words left before the next aligned boundary (a full region when aligned).
    logic [31:0] w_bound_words;
    assign w_bound_words = ((c_BOUND_MASK - (r_cur_addr & c_BOUND_MASK)) + 32'd1)
                           / 32'(c_WORD_BYTES);
`endif

    // Current burst length; r_remaining and r_cur_addr only move at burst end,
    // so this stays stable across the command and data phases of a burst.
    always_comb begin
        if (r_remaining >= LEN_W'(BURST_MAX)) begin
            w_blen = BLEN_W'(BURST_MAX);
        end else begin
            w_blen = r_remaining[BLEN_W-1:0];
        end
`ifdef MANNIX_DDR_BOUNDARY_EN
        if (w_bound_words < 32'(w_blen)) begin
            w_blen = w_bound_words[BLEN_W-1:0];
        end
`endif
    end

    assign w_beat      = ((r_state == RD_DATA) && bus.ddr_rdata_valid) ||
                         ((r_state == WR_DATA) && bus.wr_data_valid && bus.ddr_wdata_ready);
    assign w_burst_end = w_beat && (r_beat_cnt == (w_blen - BLEN_W'(1)));
    // Last beat of the whole request: this burst consumes everything left.
    assign w_req_end   = w_burst_end && (r_remaining == LEN_W'(w_blen));

    assign w_rd_grant  = bus.rd_req_valid && w_rd_req_ready;
    assign w_wr_grant  = bus.wr_req_valid && w_wr_req_ready;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rd_req_ready    = 1'b0;
        w_wr_req_ready    = 1'b0;
        w_cmd_valid       = 1'b0;
        w_wr_data_ready   = 1'b0;
        w_ddr_wdata_valid = 1'b0;
        w_rd_done         = 1'b0;
        w_wr_done         = 1'b0;
        case (r_state)
            IDLE: begin
                // Only one side is ready when both request, so at most one
                // handshake happens per cycle. rst gating keeps the readies
                // low while reset is held.
                w_rd_req_ready = !rst && (!bus.wr_req_valid || r_prefer_rd);
                w_wr_req_ready = !rst && (!bus.rd_req_valid || !r_prefer_rd);
                if (bus.rd_req_valid && w_rd_req_ready) begin
                    w_state_nxt = (bus.rd_req_len == '0) ? DONE : RD_CMD;
                end else if (bus.wr_req_valid && w_wr_req_ready) begin
                    w_state_nxt = (bus.wr_req_len == '0) ? DONE : WR_CMD;
                end
            end
            RD_CMD: begin
                w_cmd_valid = 1'b1;
                if (bus.ddr_cmd_ready) begin
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_burst_end) begin
                    w_state_nxt = w_req_end ? DONE : RD_CMD;
                end
            end
            WR_CMD: begin
                w_cmd_valid = 1'b1;
                if (bus.ddr_cmd_ready) begin
                    w_state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                w_wr_data_ready   = bus.ddr_wdata_ready;
                w_ddr_wdata_valid = bus.wr_data_valid;
                if (w_burst_end) begin
                    w_state_nxt = w_req_end ? DONE : WR_CMD;
                end
            end
            DONE: begin
                w_rd_done   = !r_is_wr;
                w_wr_done   = r_is_wr;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_beat_cnt  <= '0;
            r_is_wr     <= 1'b0;
            r_prefer_rd <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_valid <= (r_state == RD_DATA) && bus.ddr_rdata_valid;
            r_rd_last  <= (r_state == RD_DATA) && w_req_end;
            if ((r_state == RD_DATA) && bus.ddr_rdata_valid) begin
                r_rd_data <= bus.ddr_rdata;
            end

            if (w_rd_grant) begin
                r_cur_addr  <= bus.rd_req_addr & ~32'h3;
                r_remaining <= bus.rd_req_len;
                r_is_wr     <= 1'b0;
                r_prefer_rd <= 1'b0;
            end else if (w_wr_grant) begin
                r_cur_addr  <= bus.wr_req_addr & ~32'h3;
                r_remaining <= bus.wr_req_len;
                r_is_wr     <= 1'b1;
                r_prefer_rd <= 1'b1;
            end else if (w_burst_end) begin
                // blen <= remaining, so this never underflows; address wraps.
                r_cur_addr  <= r_cur_addr + 32'(w_blen) * 32'(c_WORD_BYTES);
                r_remaining <= r_remaining - LEN_W'(w_blen);
            end

            if (w_burst_end) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + BLEN_W'(1);
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.rd_req_ready    = w_rd_req_ready;
    assign bus.wr_req_ready    = w_wr_req_ready;
    assign bus.rd_data_valid   = r_rd_valid;
    assign bus.rd_data         = r_rd_data;
    assign bus.rd_data_last    = r_rd_last;
    assign bus.rd_done         = w_rd_done;
    assign bus.wr_done         = w_wr_done;
    assign bus.wr_data_ready   = w_wr_data_ready;
    assign bus.ddr_cmd_valid   = w_cmd_valid;
    assign bus.ddr_cmd_we      = r_is_wr;
    assign bus.ddr_cmd_addr    = r_cur_addr;
    assign bus.ddr_cmd_blen    = w_blen;
    assign bus.ddr_wdata_valid = w_ddr_wdata_valid;
    assign bus.ddr_wdata       = bus.wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mannix_ddr_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mannix_ddr_dma
//  Description : Directed self-checking bench for mannix_ddr_dma. A small DDR
//                responder feeds read bursts and paces write beats; a farm-side
//                driver offers write words; a monitor logs commands, beats,
//                grants and done pulses for comparison against hand-computed
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mannix_ddr_dma;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 16;
    localparam int BURST_MAX  = 16;
    localparam int BLEN_W     = 5;
    localparam int BOUND_LOG2 = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mannix_ddr_dma_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BLEN_W(BLEN_W)) bus ();

    mannix_ddr_dma #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX),
        .BLEN_W(BLEN_W), .BOUND_LOG2(BOUND_LOG2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- logs
    logic [31:0] log_addr[$];
    int          log_blen[$];
    bit          log_we[$];
    bit          grant_log[$];   // 0 = read, 1 = write
    logic [31:0] wcap[$];
    int rd_cnt, rd_last_cnt, rd_last_idx, rd_data_err, rd_done_cnt, wr_done_cnt;

    // model controls
    int rd_pending  = 0;
    int feed_idx    = 0;
    int wr_idx      = 0;
    int wr_offer_n  = 0;
    bit wr_toggle   = 1'b0;
    bit stray_req   = 1'b0;

    task automatic clear_logs();
        log_addr.delete(); log_blen.delete(); log_we.delete();
        grant_log.delete(); wcap.delete();
        rd_cnt = 0; rd_last_cnt = 0; rd_last_idx = 0; rd_data_err = 0;
        rd_done_cnt = 0; wr_done_cnt = 0;
        feed_idx = 0; wr_idx = 0;
    endtask

    // Monitor: handshakes seen at the falling edge complete on the next rise.
    always @(negedge clk) begin
        if (bus.ddr_cmd_valid && bus.ddr_cmd_ready) begin
            log_addr.push_back(bus.ddr_cmd_addr);
            log_blen.push_back(int'(bus.ddr_cmd_blen));
            log_we.push_back(bus.ddr_cmd_we);
        end
        if (bus.rd_req_valid && bus.rd_req_ready) grant_log.push_back(1'b0);
        if (bus.wr_req_valid && bus.wr_req_ready) grant_log.push_back(1'b1);
        if (bus.ddr_wdata_valid && bus.ddr_wdata_ready) wcap.push_back(bus.ddr_wdata);
        if (bus.rd_data_valid) begin
            rd_cnt++;
            if (bus.rd_data !== (32'hD000_0000 + 32'(rd_cnt - 1))) rd_data_err++;
            if (bus.rd_data_last) begin
                rd_last_cnt++;
                rd_last_idx = rd_cnt;
            end
        end
        if (bus.rd_done) rd_done_cnt++;
        if (bus.wr_done) wr_done_cnt++;
    end

    // DDR responder and farm write-data source; drive 1ns after the rise.
    initial begin : p_model
        bit s_rd_cmd;
        bit s_wr_hs;
        int s_blen;
        bus.ddr_cmd_ready   = 1'b1;
        bus.ddr_rdata_valid = 1'b0;
        bus.ddr_rdata       = '0;
        bus.ddr_wdata_ready = 1'b1;
        bus.wr_data_valid   = 1'b0;
        bus.wr_data         = '0;
        forever begin
            @(negedge clk);
            s_rd_cmd = bus.ddr_cmd_valid && bus.ddr_cmd_ready && !bus.ddr_cmd_we;
            s_blen   = int'(bus.ddr_cmd_blen);
            s_wr_hs  = bus.wr_data_valid && bus.wr_data_ready;
            @(posedge clk);
            #1;
            if (s_wr_hs) wr_idx++;
            bus.wr_data_valid   = (wr_idx < wr_offer_n);
            bus.wr_data         = 32'hC000_0000 + 32'(wr_idx);
            bus.ddr_wdata_ready = wr_toggle ? ~bus.ddr_wdata_ready : 1'b1;
            bus.ddr_cmd_ready   = wr_toggle ? ~bus.ddr_cmd_ready : 1'b1;
            if (rst) rd_pending = 0;
            if (rd_pending > 0) begin
                bus.ddr_rdata_valid = 1'b1;
                bus.ddr_rdata       = 32'hD000_0000 + 32'(feed_idx);
                feed_idx++;
                rd_pending--;
            end else if (stray_req) begin
                bus.ddr_rdata_valid = 1'b1;
                bus.ddr_rdata       = 32'hBAD0_0000;
                stray_req           = 1'b0;
            end else begin
                bus.ddr_rdata_valid = 1'b0;
            end
            if (s_rd_cmd && !rst) rd_pending = s_blen;
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic send_req(input bit is_wr, input logic [31:0] addr, input int len);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if (is_wr) begin
            bus.wr_req_valid = 1'b1; bus.wr_req_addr = addr; bus.wr_req_len = LEN_W'(len);
        end else begin
            bus.rd_req_valid = 1'b1; bus.rd_req_addr = addr; bus.rd_req_len = LEN_W'(len);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (is_wr ? (bus.wr_req_ready === 1'b1) : (bus.rd_req_ready === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
        bus.wr_req_valid = 1'b0;
        if (!ok) check("req_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int rd_exp, input int wr_exp, input int max_cyc, input string tag);
        int n = 0;
        while ((rd_done_cnt < rd_exp || wr_done_cnt < wr_exp) && n < max_cyc) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_rd_done"}, 32'(rd_done_cnt), 32'(rd_exp));
        check({tag, "_wr_done"}, 32'(wr_done_cnt), 32'(wr_exp));
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic [31:0] addr,
                             input int blen, input bit we);
        logic [31:0] a = 32'hDEAD_DEAD;
        logic [31:0] f = 32'hDEAD_DEAD;
        if (idx < log_addr.size()) begin
            a = log_addr[idx];
            f = {log_we[idx] ? 16'h1 : 16'h0, 16'(log_blen[idx])};
        end
        check({tag, "_addr"}, a, addr);
        check({tag, "_we_blen"}, f, {we ? 16'h1 : 16'h0, 16'(blen)});
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- tests
    initial begin : p_main
        logic [3:0] g;
        bus.rd_req_valid = 1'b0; bus.rd_req_addr = '0; bus.rd_req_len = '0;
        bus.wr_req_valid = 1'b0; bus.wr_req_addr = '0; bus.wr_req_len = '0;
        clear_logs();

        // reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready", {30'd0, bus.rd_req_ready, bus.wr_req_ready}, 32'd0);
        check("rst_cmd", {25'd0, bus.ddr_cmd_valid, bus.ddr_cmd_we, bus.ddr_cmd_blen}, 32'd0);
        check("rst_cmd_addr", bus.ddr_cmd_addr, 32'd0);
        check("rst_outs", {26'd0, bus.rd_data_valid, bus.rd_data_last, bus.rd_done,
                           bus.wr_done, bus.wr_data_ready, bus.ddr_wdata_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {30'd0, bus.rd_req_ready, bus.wr_req_ready}, 32'd3);

        // stray read beat while idle is ignored
        clear_logs();
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("stray_ignored", 32'(rd_cnt), 32'd0);

        // read 0x100 len 40 -> 16+16+8
        clear_logs();
        send_req(1'b0, 32'h100, 40);
        wait_done(1, 0, 400, "rd40");
        check("rd40_ncmd", 32'(log_addr.size()), 32'd3);
        check_cmd("rd40_c0", 0, 32'h100, 16, 1'b0);
        check_cmd("rd40_c1", 1, 32'h140, 16, 1'b0);
        check_cmd("rd40_c2", 2, 32'h180, 8, 1'b0);
        check("rd40_beats", 32'(rd_cnt), 32'd40);
        check("rd40_last_cnt", 32'(rd_last_cnt), 32'd1);
        check("rd40_last_idx", 32'(rd_last_idx), 32'd40);
        check("rd40_data_err", 32'(rd_data_err), 32'd0);

        // write 0x2000 len 5, DDR ready toggling; farm offers 8 words
        clear_logs();
        wr_offer_n = 8;
        wr_toggle  = 1'b1;
        send_req(1'b1, 32'h2000, 5);
        wait_done(0, 1, 200, "wr5");
        wr_toggle  = 1'b0;
        wr_offer_n = 0;
        check("wr5_ncmd", 32'(log_addr.size()), 32'd1);
        check_cmd("wr5_c0", 0, 32'h2000, 5, 1'b1);
        check("wr5_beats", 32'(wcap.size()), 32'd5);
        check("wr5_farm_taken", 32'(wr_idx), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr5_data%0d", i), (i < wcap.size()) ? wcap[i] : 32'hDEAD_DEAD,
                  32'hC000_0000 + 32'(i));
        end

        // both requests held high: grants must alternate R, W, R, W
        clear_logs();
        wr_offer_n = 2;
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b1; bus.rd_req_addr = 32'h300; bus.rd_req_len = LEN_W'(1);
        bus.wr_req_valid = 1'b1; bus.wr_req_addr = 32'h400; bus.wr_req_len = LEN_W'(1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= 4) break;
        end
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
        bus.wr_req_valid = 1'b0;
        wait_done(2, 2, 100, "arb");
        wr_offer_n = 0;
        g = '0;
        for (int i = 0; i < 4; i++) if (i < grant_log.size()) g[i] = grant_log[i];
        check("arb_ngrant", 32'(grant_log.size()), 32'd4);
        check("arb_order", {28'd0, g}, 32'b1010);
        check("arb_ncmd", 32'(log_addr.size()), 32'd4);
        check("arb_wbeats", 32'(wcap.size()), 32'd2);

        // zero-length read
        clear_logs();
        send_req(1'b0, 32'h40, 0);
        wait_done(1, 0, 2, "len0");
        check("len0_ncmd", 32'(log_addr.size()), 32'd0);
        check("len0_beats", 32'(rd_cnt), 32'd0);

        // unaligned start address is forced to word alignment
        clear_logs();
        send_req(1'b0, 32'h103, 1);
        wait_done(1, 0, 50, "unal");
        check_cmd("unal_c0", 0, 32'h100, 1, 1'b0);

        // boundary behaviour at 0xFF8
        clear_logs();
        send_req(1'b0, 32'hFF8, 10);
        wait_done(1, 0, 100, "bnd");
        check("bnd_beats", 32'(rd_cnt), 32'd10);
`ifdef MANNIX_DDR_BOUNDARY_EN
        check("bnd_ncmd", 32'(log_addr.size()), 32'd2);
        check_cmd("bnd_c0", 0, 32'hFF8, 2, 1'b0);
        check_cmd("bnd_c1", 1, 32'h1000, 8, 1'b0);
`else
        check("bnd_ncmd", 32'(log_addr.size()), 32'd1);
        check_cmd("bnd_c0", 0, 32'hFF8, 10, 1'b0);
`endif

        // reset in the middle of a read burst
        clear_logs();
        send_req(1'b0, 32'h500, 16);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (rd_cnt >= 3) break;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {23'd0, bus.ddr_cmd_valid, bus.rd_data_valid, bus.rd_data_last,
                               bus.rd_done, bus.wr_done, bus.rd_req_ready, bus.wr_req_ready,
                               bus.wr_data_ready, bus.ddr_wdata_valid}, 32'd0);
        check("mid_rst_cmd", {26'd0, bus.ddr_cmd_we, bus.ddr_cmd_blen}, 32'd0);
        check("mid_rst_addr", bus.ddr_cmd_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("mid_rst_no_done", 32'(rd_done_cnt), 32'd0);

        clear_logs();
        send_req(1'b0, 32'h600, 3);
        wait_done(1, 0, 100, "post_rst");
        check_cmd("post_rst_c0", 0, 32'h600, 3, 1'b0);
        check("post_rst_beats", 32'(rd_cnt), 32'd3);
        check("post_rst_last_idx", 32'(rd_last_idx), 32'd3);
        check("post_rst_data_err", 32'(rd_data_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mannix_ddr_dma.md
Name: mannix_ddr_dma

Overview:
- Bridges the mannix memory farm's DDR request paths to the external DDR controller port.
- Accepts word-granular read and write transfer requests of arbitrary length from the farm.
- Splits each request into DDR bursts, arbitrates read against write, and streams data in both directions.
- Sits directly downstream of the memory farm's read_ddr_req/write_ddr_req outputs.

Parameters:
- DATA_W, 32, data word width in bits; byte address step per word = DATA_W/8.
- LEN_W, 16, width of request length field, in words.
- BURST_MAX, 16, maximum beats per DDR burst, power of two.
- BLEN_W, 5, width of ddr_cmd_blen; must hold BURST_MAX.
- BOUND_LOG2, 12, log2 of the byte boundary no burst may cross (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rd_req_valid  in  1  farm read request valid
- rd_req_addr  in  32  read start byte address
- rd_req_len  in  LEN_W  read length, words
- rd_req_ready  out  1  read request accepted when valid&ready
- rd_data_valid  out  1  read data beat to farm, no backpressure
- rd_data  out  DATA_W  read data
- rd_data_last  out  1  final beat of the whole request
- rd_done  out  1  one-cycle pulse, read request complete
- wr_req_valid  in  1  farm write request valid
- wr_req_addr  in  32  write start byte address
- wr_req_len  in  LEN_W  write length, words
- wr_req_ready  out  1  write request accepted
- wr_data_valid  in  1  farm write data valid
- wr_data  in  DATA_W  write data
- wr_data_ready  out  1  write data accepted
- wr_done  out  1  one-cycle pulse, write request complete
- ddr_cmd_valid  out  1  DDR command valid
- ddr_cmd_ready  in  1  DDR command accepted
- ddr_cmd_we  out  1  1 = write burst, 0 = read burst
- ddr_cmd_addr  out  32  burst start byte address
- ddr_cmd_blen  out  BLEN_W  burst beats, 1..BURST_MAX
- ddr_wdata_valid  out  1  write beat valid
- ddr_wdata  out  DATA_W  write beat
- ddr_wdata_ready  in  1  DDR accepts write beat
- ddr_rdata_valid  in  1  DDR read beat valid
- ddr_rdata  in  DATA_W  DDR read beat

Behaviour:
- Reset: one clock clk; reset rst is asynchronous and active-high.
  - State returns to IDLE.
  - Outputs clear to 0: all ready, valid, done and last signals; ddr_cmd_addr; ddr_cmd_blen; ddr_cmd_we.
  - Reset mid-transfer abandons the transfer; no done pulse is issued.
- FSM states: IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA, DONE.
- IDLE:
  - rd_req_ready and wr_req_ready are asserted only in IDLE.
  - When both request valids are high, grant alternates round-robin; the first grant after reset goes to read.
  - The accepted request latches cur_addr = addr with bits[1:0] forced to 0, and remaining = len.
  - len = 0: request is accepted, no DDR traffic, go to DONE.
- Burst length: blen = min(remaining, BURST_MAX).
- RD_CMD / WR_CMD:
  - ddr_cmd_valid is held with stable fields until ddr_cmd_ready is sampled high.
  - Then go to RD_DATA or WR_DATA.
- RD_DATA:
  - Each ddr_rdata_valid beat is forwarded registered: rd_data_valid and rd_data follow one cycle later.
  - rd_data_last is high on the beat where remaining reaches 0.
  - After blen beats: cur_addr += blen*4; remaining -= blen.
  - Next state is RD_CMD if remaining ≠ 0, else DONE.
  - Only one burst is outstanding at a time.
- WR_DATA:
  - wr_data_ready = ddr_wdata_ready; ddr_wdata_valid = wr_data_valid (combinational pass-through).
  - A beat counts on wr_data_valid & ddr_wdata_ready.
  - After blen beats, same address/remaining update and next-state rule as RD_DATA.
  - wr_data_ready is 0 outside WR_DATA.
- DONE: pulse rd_done or wr_done for exactly 1 cycle, then IDLE.
  - For reads, rd_done coincides with or follows the rd_data_last beat.
- Arithmetic: cur_addr wraps modulo 2^32. remaining never underflows.
- Stray ddr_rdata_valid outside RD_DATA is ignored.

Optional Feature:
- Macro MANNIX_DDR_BOUNDARY_EN.
- Defined: blen = min(remaining, BURST_MAX, words to the next 2^BOUND_LOG2 byte boundary from cur_addr); no burst crosses the boundary.
- Undefined: the boundary term is absent; bursts are split by BURST_MAX only.

Test Plan:
- Read addr 0x100, len 40, BURST_MAX 16 -> cmds (0x100,16), (0x140,16), (0x180,8); 40 rd_data beats; rd_data_last on beat 40; one rd_done.
- Write addr 0x2000, len 5, ddr_wdata_ready toggling 1/0 -> one cmd (0x2000,5); exactly 5 beats accepted with order preserved; one wr_done.
- rd_req_valid and wr_req_valid held high simultaneously, len 1 each, repeated 4 times -> grants alternate R, W, R, W.
- Read len 0 at addr 0x40 -> no ddr_cmd_valid, rd_done pulses within 2 cycles, no rd_data_valid.
- MANNIX_DDR_BOUNDARY_EN defined, read addr 0xFF8, len 10 -> cmds (0xFF8,2), (0x1000,8). Undefined -> cmd (0xFF8,10).
- rst asserted during RD_DATA after 3 of 16 beats -> all outputs 0 asynchronously, no done pulse; next request runs normally.
